// File: rtl/tree_mac_pkg.sv
// rtl/tree_mac_pkg.sv - shared types and constants for the tree MAC controller
package tree_mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FINAL,
    S_OUT,
    S_DONE
  } state_e;

  localparam int ACC_W_DEF = 40;

  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

  // Largest supported buffer read latency; sizes the drain counter.
  localparam int RD_LAT_MAX = 4;
  localparam int DRN_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/tree_mac_ctrl_sat_relu32.sv
// rtl/tree_mac_ctrl_sat_relu32.sv - optional ReLU then clamp of a wide signed sum to 32 bits
module sat_relu32
  import tree_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W:0] sum_i,
  input  logic                  relu_i,
  output logic signed [31:0]    data_o
);

  localparam logic signed [ACC_W:0] HI = {{(ACC_W - 31){1'b0}}, SAT_MAX};
  localparam logic signed [ACC_W:0] LO = {{(ACC_W - 31){1'b1}}, SAT_MIN};

  // ReLU takes priority: any negative sum becomes zero before clamping.
  always_comb begin
    data_o = sum_i[31:0];
    if (relu_i && sum_i[ACC_W]) begin
      data_o = '0;
    end else if (sum_i > HI) begin
      data_o = SAT_MAX;
    end else if (sum_i < LO) begin
      data_o = SAT_MIN;
    end
  end

endmodule

// File: rtl/tree_mac_ctrl.sv
// rtl/tree_mac_ctrl.sv - chunk sequencer, accumulator and result port for the 32-lane tree adder
module tree_mac_ctrl
  import tree_mac_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10,
  parameter int RD_LAT = 1,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         cfg_num_out,
  input  logic [CNT_W-1:0]         cfg_num_chunks,
  input  logic                     cfg_relu,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        w_addr,
  output logic [CNT_W-1:0]         x_addr,
  output logic [CNT_W-1:0]         b_addr,
  input  logic signed [31:0]       tree_sum,
  input  logic signed [31:0]       bias_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [31:0]       out_data,
  output logic [CNT_W-1:0]         out_idx
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      num_out_q, num_out_d;
  logic [CNT_W-1:0]      num_chunks_q, num_chunks_d;
  logic                  relu_q, relu_d;
  logic [ADDR_W-1:0]     w_addr_q, w_addr_d;
  logic [CNT_W-1:0]      chunk_q, chunk_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [31:0]           bias_q, bias_d;
  logic [DRN_W-1:0]      drain_q, drain_d;
  logic signed [31:0]    res_q, res_d;
  logic [RD_LAT-1:0]     vpipe_q;
  logic [RD_LAT-1:0]     fpipe_q;
  logic signed [ACC_W:0] sum_w;
  logic signed [31:0]    sat_w;

  // One extra bit so acc + bias can never wrap before the clamp.
  assign sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W - 31){bias_q[31]}}, bias_q};

  sat_relu32 #(.ACC_W(ACC_W)) u_sat (
    .sum_i  (sum_w),
    .relu_i (relu_q),
    .data_o (sat_w)
  );

  assign busy     = (state_q != S_IDLE);
  assign w_addr   = w_addr_q;
  assign x_addr   = chunk_q;
  assign b_addr   = idx_q;
  assign out_idx  = idx_q;
  assign out_data = res_q;

  // Next-state, datapath updates and strobes.
  always_comb begin
    state_d      = state_q;
    num_out_d    = num_out_q;
    num_chunks_d = num_chunks_q;
    relu_d       = relu_q;
    w_addr_d     = w_addr_q;
    chunk_d      = chunk_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    bias_d       = bias_q;
    drain_d      = drain_q;
    res_d        = res_q;
    mem_rd_en    = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;

    // Read returns land whenever their flag leaves the delay line.
    if (vpipe_q[RD_LAT-1]) acc_d = acc_q + {{(ACC_W - 32){tree_sum[31]}}, tree_sum};
    if (fpipe_q[RD_LAT-1]) bias_d = bias_data;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_out_d    = cfg_num_out;
          num_chunks_d = cfg_num_chunks;
          relu_d       = cfg_relu;
          w_addr_d     = '0;
          chunk_d      = '0;
          idx_d        = '0;
          acc_d        = '0;
          state_d      = (cfg_num_out == '0 || cfg_num_chunks == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd_en = 1'b1;
        w_addr_d  = w_addr_q + 1'b1;
        if (chunk_q == num_chunks_q - 1'b1) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRN_W'(RD_LAT - 1)) state_d = S_FINAL;
        else drain_d = drain_q + 1'b1;
      end
      S_FINAL: begin
        res_d   = sat_w;
        state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          chunk_d = '0;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == num_out_q - 1'b1) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_out_q    <= '0;
      num_chunks_q <= '0;
      relu_q       <= 1'b0;
      w_addr_q     <= '0;
      chunk_q      <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      bias_q       <= '0;
      drain_q      <= '0;
      res_q        <= '0;
    end else begin
      num_out_q    <= num_out_d;
      num_chunks_q <= num_chunks_d;
      relu_q       <= relu_d;
      w_addr_q     <= w_addr_d;
      chunk_q      <= chunk_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      bias_q       <= bias_d;
      drain_q      <= drain_d;
      res_q        <= res_d;
    end
  end

  // Read-tracking delay lines: every issued read, and the chunk-0 read that carries the bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q <= '0;
      fpipe_q <= '0;
    end else begin
      vpipe_q[0] <= mem_rd_en;
      fpipe_q[0] <= mem_rd_en && (chunk_q == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        fpipe_q[i] <= fpipe_q[i-1];
      end
    end
  end

endmodule

// File: doc/tree_mac_ctrl.md
# tree_mac_ctrl

Sequencing controller for the 32-lane combinational tree adder in the dense/convolution datapath. For each output neuron it walks the weight and activation buffers one 32-lane chunk per cycle and accumulates the tree adder's 32-bit partial sums. It then adds a per-output bias, applies optional ReLU and 32-bit saturation, and hands each result downstream over a valid/ready port. Software starts one layer pass with a single `start` pulse.

## Interface
Parameters:
- `ADDR_W`, 12: weight buffer address width.
- `CNT_W`, 10: width of the output and chunk counters.
- `RD_LAT`, 1: fixed buffer read latency in cycles, from `mem_rd_en` to valid `tree_sum` / `bias_data`. Legal range 1..4.
- `ACC_W`, 40: signed accumulator width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a pass; sampled only in IDLE.
- `cfg_num_out` in CNT_W: number of outputs; latched on start.
- `cfg_num_chunks` in CNT_W: 32-lane chunks per output; latched on start.
- `cfg_relu` in 1: enable ReLU; latched on start.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle completion pulse.
- `mem_rd_en` out 1: read strobe to the weight, activation and bias buffers.
- `w_addr` out ADDR_W: weight chunk address.
- `x_addr` out CNT_W: activation chunk index.
- `b_addr` out CNT_W: bias address, equal to the current output index.
- `tree_sum` in 32 signed: tree adder result, valid RD_LAT cycles after its read.
- `bias_data` in 32 signed: bias value, valid RD_LAT cycles after the chunk-0 read.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 32 signed: saturated result.
- `out_idx` out CNT_W: output index of `out_data`.

## Operation
States: IDLE, FETCH, DRAIN, FINAL, OUT, DONE.
- IDLE:
  - `start` latches the cfg fields and clears `w_addr`, the output index, the chunk index and the accumulator.
  - If `cfg_num_out`==0 or `cfg_num_chunks`==0, go to DONE. Otherwise go to FETCH.
  - A `start` received in any other state is ignored.
- FETCH:
  - `mem_rd_en`=1 every cycle.
  - `x_addr` = chunk index. `w_addr` increments after each read and runs contiguously across outputs (0..num_out*num_chunks-1, wraps modulo 2^ADDR_W).
  - After chunk num_chunks-1, go to DRAIN.
- Accumulate path:
  - A delay line of RD_LAT flags tracks issued reads.
  - When a flag emerges: acc += sign-extended `tree_sum`.
  - When the chunk-0 flag emerges: capture `bias_data`.
- DRAIN: `mem_rd_en`=0. Stay RD_LAT cycles, then go to FINAL.
- FINAL: register r = sat32(relu(acc + bias)), then go to OUT.
  - relu: r<0 becomes 0 when `cfg_relu`=1.
  - sat32: clamp to [-2^31, 2^31-1].
  - Width rules: acc + bias is computed at ACC_W+1 bits, with no wrap before saturation.
- OUT: `out_valid`=1, with `out_data` and `out_idx` stable.
  - On `out_valid`&&`out_ready`: clear acc and the chunk index, increment the output index.
  - Then go to FETCH, or to DONE after the last output.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy` = state != IDLE.

Reset:
- All outputs are 0 after reset: busy, done, mem_rd_en, w_addr, x_addr, b_addr, out_valid, out_data, out_idx.
- Reset asserted mid-pass abandons the pass immediately. The next `start` begins again from `w_addr`=0.

## Timing
- Let t1 be the first `mem_rd_en` cycle (the cycle after `start` is sampled). `out_valid` first rises at t1+N+RD_LAT+1, with N = num_chunks.
- Per-output period without stall: N+RD_LAT+2 cycles.
- No reads are issued while in OUT. Backpressure stalls the controller only; no data is dropped.
- `done` rises the cycle after the last handshake, or the cycle after `start` for a zero-size pass.

## Structure
- Shared package `tree_mac_pkg`:
  - state enum,
  - ACC_W default,
  - SAT_MAX / SAT_MIN constants,
  - RD_LAT bound.
- One natural sub-module, `sat_relu32`: combinational ACC_W+1 → 32 ReLU plus clamp, instanced in FINAL.

## Test plan
1. num_out=1, chunks=1, tree_sum=100, bias=5, relu=0 → out_data=105, out_idx=0 at t1+3; done pulses the cycle after the handshake.
2. chunks=4, tree_sum 1000,-200,300,-50, bias=-2000:
   - relu=0 → -950.
   - relu=1 → 0.
   - bias=-1000, relu=1 → 50.
3. chunks=3, tree_sum=0x7FFFFFFF each, bias=0x7FFFFFFF → 0x7FFFFFFF. tree_sum=0x80000000 each, relu=0 → 0x80000000.
4. num_out=3, chunks=2, out_ready held low 5 cycles on output 1:
   - out_data and out_idx stable during the stall;
   - no mem_rd_en during the stall;
   - w_addr sequence 0..5;
   - out_idx sequence 0, 1, 2.
5. num_out=0 → done the cycle after start, no mem_rd_en. A start pulse while busy changes nothing.
6. rst_n low during FETCH → all outputs 0 within the same cycle. After release, a new start with chunks=1 produces w_addr=0 and a correct result.
